// File: rtl/usb_pkg.sv
// Shared USB line-level types: line states, packet-type codes and the tx FSM state.
// Also holds the dp/dm decode and the NRZI step used by the transmitter.
package usb_pkg;

   typedef enum logic [1:0] {
      LS_J,
      LS_K,
      LS_SE0
   } line_state_t;

   localparam logic [1:0] PT_NONE      = 2'b00;
   localparam logic [1:0] PT_TOKEN     = 2'b01;
   localparam logic [1:0] PT_DATA      = 2'b10;
   localparam logic [1:0] PT_HANDSHAKE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_EOP_SE0,
      ST_EOP_J
   } tx_state_t;

   // Returns {dp, dm}.
   function automatic logic [1:0] line_to_dpdm(input line_state_t ls);
      logic [1:0] pair;
      case (ls)
         LS_J:    pair = 2'b10;
         LS_K:    pair = 2'b01;
         default: pair = 2'b00;
      endcase
      return pair;
   endfunction

   // A 0 toggles J<->K, a 1 holds the level.
   function automatic line_state_t nrzi_next(input line_state_t level, input logic b);
      line_state_t nxt;
      case (level)
         LS_J:    nxt = b ? LS_J : LS_K;
         LS_K:    nxt = b ? LS_K : LS_J;
         default: nxt = LS_J;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/nrzi_ones_mon.sv
// Tracks the run of consecutive 1s on a serial stream and flags runs longer than
// MAX_ONES; the run length saturates so the flag repeats while the run continues.
import usb_pkg::*;

module nrzi_ones_mon #(
   parameter int MAX_ONES = 6,
   parameter int RUN_W    = $clog2(MAX_ONES + 2)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic bit_valid,
   input  logic bit_in,
   output logic stuff_err
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_ONES + 1);

   logic [RUN_W-1:0] run_len;
   logic [RUN_W-1:0] run_next;

   // clear marks the first bit of a packet, so that bit starts a fresh run.
   always_comb begin
      run_next = run_len;
      if (bit_valid) begin
         if (!bit_in)
            run_next = '0;
         else if (clear)
            run_next = RUN_W'(1);
         else if (run_len != RUN_MAX)
            run_next = run_len + RUN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_len   <= '0;
         stuff_err <= 1'b0;
      end else begin
         run_len   <= run_next;
         stuff_err <= bit_valid && bit_in && (run_next == RUN_MAX);
      end
   end

endmodule

// File: rtl/nrzi_line_tx.sv
// NRZI line transmitter: encodes the stuffed bit stream onto dp/dm, appends the
// EOP (SE0 bit times then one J) and reports completion, bit count and stream errors.
import usb_pkg::*;

module nrzi_line_tx #(
   parameter int EOP_SE0_BITS = 2,
   parameter int CNT_W        = 8,
   parameter int MAX_ONES     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bstr_in,
   input  logic [1:0]       bstr_in_ready,
   output logic             dp,
   output logic             dm,
   output logic             busy,
   output logic [1:0]       pkt_type,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             done,
   output logic             overrun_err,
   output logic             stuff_err,
   output logic             type_err,
   output tx_state_t        state
);

   localparam int SE0_W = 2;

   // Handshake: bstr_in is a bit only when bstr_in_ready != PT_NONE. There is no
   // back-pressure; a packet is the contiguous run of such cycles, and the first
   // PT_NONE cycle after it ends the packet. Bits offered during the EOP are dropped.
   logic             in_valid;
   logic             pkt_start;
   logic             bit_taken;
   line_state_t      level;
   logic [SE0_W-1:0] se0_cnt;

   assign in_valid  = (bstr_in_ready != PT_NONE);
   assign pkt_start = in_valid && (state == ST_IDLE);
   assign bit_taken = in_valid && ((state == ST_IDLE) || (state == ST_DATA));
   assign busy      = (state != ST_IDLE);

   nrzi_ones_mon #(
      .MAX_ONES (MAX_ONES)
   ) u_ones_mon (
      .clk       (clk),
      .rst       (rst),
      .clear     (pkt_start),
      .bit_valid (bit_taken),
      .bit_in    (bstr_in),
      .stuff_err (stuff_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         level       <= LS_J;
         {dp, dm}    <= line_to_dpdm(LS_J);
         pkt_type    <= PT_NONE;
         bit_cnt     <= '0;
         se0_cnt     <= '0;
         done        <= 1'b0;
         overrun_err <= 1'b0;
         type_err    <= 1'b0;
      end else begin
         done        <= 1'b0;
         overrun_err <= 1'b0;
         type_err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               {dp, dm} <= line_to_dpdm(LS_J);
               // The EOP always leaves the line at J, so every packet encodes from J.
               if (in_valid) begin
                  state    <= ST_DATA;
                  pkt_type <= bstr_in_ready;
                  bit_cnt  <= CNT_W'(1);
                  level    <= nrzi_next(LS_J, bstr_in);
                  {dp, dm} <= line_to_dpdm(nrzi_next(LS_J, bstr_in));
               end
            end
            ST_DATA: begin
               if (in_valid) begin
                  level    <= nrzi_next(level, bstr_in);
                  {dp, dm} <= line_to_dpdm(nrzi_next(level, bstr_in));
                  if (bit_cnt != '1)
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  type_err <= (bstr_in_ready != pkt_type);
               end else begin
                  state    <= ST_EOP_SE0;
                  se0_cnt  <= SE0_W'(1);
                  {dp, dm} <= line_to_dpdm(LS_SE0);
               end
            end
            ST_EOP_SE0: begin
               overrun_err <= in_valid;
               if (se0_cnt == SE0_W'(EOP_SE0_BITS)) begin
                  state    <= ST_EOP_J;
                  done     <= 1'b1;
                  {dp, dm} <= line_to_dpdm(LS_J);
               end else begin
                  se0_cnt  <= se0_cnt + SE0_W'(1);
                  {dp, dm} <= line_to_dpdm(LS_SE0);
               end
            end
            ST_EOP_J: begin
               overrun_err <= in_valid;
               state       <= ST_IDLE;
               level       <= LS_J;
               {dp, dm}    <= line_to_dpdm(LS_J);
            end
            default: begin
               state    <= ST_IDLE;
               {dp, dm} <= line_to_dpdm(LS_J);
            end
         endcase
      end
   end

endmodule

// File: doc/nrzi_line_tx.md
Name: nrzi_line_tx

Overview:
- Stage directly downstream of the bit stuffer.
- Consumes the stuffed serial stream plus its 2-bit packet-type/valid code, NRZI-encodes it, and drives the USB differential pair (dp/dm).
- Appends the End-Of-Packet sequence (SE0 bit times followed by one J) when the stream ends.
- Reports packet completion, per-packet bit count, and stream errors (overrun, stuffing violation, packet-type change).

Parameters:
- EOP_SE0_BITS, 2, number of SE0 bit times in the EOP; legal values 1..3.
- CNT_W, 8, width of the transmitted-bit counter; the counter saturates at all-ones.
- MAX_ONES, 6, longest legal run of input 1s; a run of MAX_ONES+1 flags stuff_err.

Ports:
- clk  in  1  bit clock; one line bit per cycle.
- rst  in  1  synchronous, active-high reset.
- bstr_in  in  1  stuffed data bit; valid when bstr_in_ready != 0.
- bstr_in_ready  in  2  packet type; 2'b00 = no bit this cycle.
- dp  out  1  D+ line, registered.
- dm  out  1  D- line, registered.
- busy  out  1  high whenever state != IDLE.
- pkt_type  out  2  type latched on the first bit of the current packet.
- bit_cnt  out  CNT_W  data bits sent in the current or last packet.
- done  out  1  one-cycle pulse during the final EOP J bit.
- overrun_err  out  1  one-cycle pulse: bit offered while in EOP; the bit is dropped.
- stuff_err  out  1  one-cycle pulse: (MAX_ONES+1)th consecutive input 1.
- type_err  out  1  one-cycle pulse: nonzero bstr_in_ready differs from pkt_type mid-packet.

Behaviour:
- Line states: J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0.
- Reset: dp=1, dm=0, state=IDLE, nrzi level=J, pkt_type=0, bit_cnt=0, ones count=0, all pulse outputs 0. Reset mid-packet or mid-EOP aborts immediately; the next cycle drives J.
- FSM states: IDLE, DATA, EOP_SE0, EOP_J.
- IDLE: line holds J. A valid input moves to DATA, latches pkt_type, and sets bit_cnt=1. The bit is encoded from level J.
- DATA: each valid input bit increments bit_cnt (saturating).
- NRZI rule: a 0 toggles the line level J<->K; a 1 holds it.
- Latency: an input bit sampled at edge n appears on dp/dm from edge n until edge n+1, which is 1 cycle of register latency.
- End of packet: bstr_in_ready==0 while in DATA -> EOP_SE0. SE0 is driven for EOP_SE0_BITS cycles (internal counter), then EOP_J.
- EOP_J: drives J for one cycle with done=1, then goes to IDLE. A new packet can start on the cycle after EOP_J, i.e. it is accepted when the registered state is IDLE.
- Input gaps: a packet is a contiguous run of valid cycles; there is no mid-packet gap.
- Overrun: valid input while state is EOP_SE0 or EOP_J -> overrun_err pulse, bit dropped, EOP continues unchanged.
- type_err: pulses when the input type differs from pkt_type in DATA. The latched pkt_type is kept, and the bit is still encoded and counted.
- stuff_err: the consecutive-ones counter counts input 1s, clears on a 0 and at packet start, and saturates. stuff_err pulses each cycle the count reaches MAX_ONES+1 or more. The bit is still encoded.
- bit_cnt and pkt_type hold their values after done until the next packet start.
- nrzi level resets to J at every packet start, because the EOP leaves the line in J.

Decomposition:
- usb_pkg holds: the line-state enum {LS_J, LS_K, LS_SE0} with its dp/dm mapping function, the packet-type constants (PT_NONE=2'b00, etc.), and the tx FSM state enum.
- One natural sub-module: nrzi_ones_mon, which tracks the consecutive-ones run and generates stuff_err, so it can be reused on the receive side.
- The rest is a single always_ff FSM plus the output register.

Test Plan:
- Reset then idle 5 cycles -> dp/dm = 1/0 throughout; busy=0; all error pulses 0.
- Bits 0,1,0,0 with type 2'b01, then ready=0 -> line K,K,J,K, then SE0,SE0, then J with done=1. bit_cnt=4, pkt_type=01, busy falls the cycle after done.
- Seven consecutive 1s with type 2'b10 -> line held at J for all 7 bits; stuff_err pulses on the 7th bit only; bit_cnt=7.
- Valid bit offered on the first SE0 cycle -> overrun_err=1 that cycle; EOP timing unchanged (2 SE0 + 1 J); bit_cnt unchanged.
- Packet type 01 for 3 bits then 11 for 1 bit -> type_err pulses on the 4th bit; pkt_type stays 01; bit_cnt=4.
- rst asserted during the 2nd data bit -> next cycle dp/dm=1/0, busy=0, bit_cnt=0. A new packet starting 1 cycle after rst deasserts encodes from level J.
